// File: rtl/zbuf_clear_if.sv
// Rasterizer request channel and BRAM port A write bus of the depth-buffer clear engine.
// The engine takes the slave view; the request source / memory side takes the master view.
interface zbuf_clear_if #(
  parameter int ADDR_W = 17,
  parameter int Z_W    = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [Z_W-1:0]    req_wdata;
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [Z_W-1:0]    bram_din;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, bram_en, bram_we, bram_addr, bram_din
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, bram_en, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/zbuf_clear.sv
// Depth-buffer clear engine: on start, writes CLEAR_VAL to every cell one per cycle,
// otherwise forwards rasterizer depth requests straight to BRAM port A.
module zbuf_clear #(
  parameter int              H_RES     = 320,
  parameter int              V_RES     = 240,
  parameter int              ADDR_W    = 17,
  parameter int              Z_W       = 8,
  parameter logic [Z_W-1:0]  CLEAR_VAL = {Z_W{1'b1}}
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_aresetn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  zbuf_clear_if.slave      bus
);

  localparam int unsigned       N     = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N - 1);
  localparam logic [ADDR_W:0]   N_EXT = (ADDR_W + 1)'(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              ready;
  logic              accept;
  logic              en, we;
  logic [ADDR_W-1:0] addr;
  logic [Z_W-1:0]    din;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < N_EXT);
  endfunction

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A start seen in IDLE wins over a same-cycle request, so the request is held off.
  assign ready  = s_axi_aresetn && (state != CLEAR) && !start;
  assign accept = bus.req_valid && ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    done      = 1'b0;
    en        = 1'b0;
    we        = 1'b0;
    addr      = '0;
    din       = '0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        busy = 1'b1;
        en   = 1'b1;
        we   = 1'b1;
        addr = cnt;
        din  = CLEAR_VAL;
        if (cnt == LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // ready is never high in CLEAR, so this cannot collide with sweep writes.
    if (accept && addr_in_range(bus.req_addr)) begin
      en   = 1'b1;
      we   = bus.req_we;
      addr = bus.req_addr;
      din  = bus.req_wdata;
    end
  end

  assign bus.req_ready = ready;
  assign bus.bram_en   = en;
  assign bus.bram_we   = we;
  assign bus.bram_addr = addr;
  assign bus.bram_din  = din;

endmodule

// File: tb/tb_zbuf_clear.sv
// Directed bench for zbuf_clear: a small 4x2 instance for protocol detail and a
// default 320x240 instance for full-frame sweep length.
module tb_zbuf_clear;

  logic clk;
  logic rst_n;
  logic start;
  logic busy, done;
  logic start_big;
  logic busy_big, done_big;

  int passes = 0;
  int total  = 0;

  zbuf_clear_if #(.ADDR_W(4),  .Z_W(8)) sif ();
  zbuf_clear_if #(.ADDR_W(17), .Z_W(8)) bif ();

  zbuf_clear #(.H_RES(4), .V_RES(2), .ADDR_W(4), .Z_W(8)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .bus           (sif)
  );

  zbuf_clear #(.H_RES(320), .V_RES(240), .ADDR_W(17), .Z_W(8)) dut_big (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .start         (start_big),
    .busy          (busy_big),
    .done          (done_big),
    .bus           (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    int writes;
    int bad_addr;
    int last_addr;
    int budget;
    bit seen_done;

    rst_n = 1'b0;
    start = 1'b0;
    start_big = 1'b0;
    sif.req_valid = 1'b1;
    sif.req_we    = 1'b1;
    sif.req_addr  = 4'd3;
    sif.req_wdata = 8'h55;
    bif.req_valid = 1'b0;
    bif.req_we    = 1'b0;
    bif.req_addr  = '0;
    bif.req_wdata = '0;

    // Reset state, with a request pending that must not be accepted
    step(); step();
    mid();
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_ready", sif.req_ready, 0);
    check("rst_en",    sif.bram_en, 0);
    check("rst_we",    sif.bram_we, 0);
    check("rst_addr",  sif.bram_addr, 0);
    check("rst_din",   sif.bram_din, 0);
    step();
    sif.req_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Basic sweep
    start = 1'b1;
    mid();
    check("start_ready_low", sif.req_ready, 0);
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mid();
      check("sw1_en",   sif.bram_en, 1);
      check("sw1_we",   sif.bram_we, 1);
      check("sw1_addr", sif.bram_addr, i);
      check("sw1_din",  sif.bram_din, 8'hFF);
      check("sw1_busy", busy, 1);
      check("sw1_done", done, 0);
      step();
    end
    mid();
    check("sw1_done_pulse", done, 1);
    check("sw1_done_busy",  busy, 0);
    check("sw1_done_en",    sif.bram_en, 0);
    step();
    mid();
    check("sw1_after_done", done, 0);
    check("idle_ready",     sif.req_ready, 1);

    // Passthrough write in IDLE
    step();
    sif.req_valid = 1'b1;
    sif.req_we    = 1'b1;
    sif.req_addr  = 4'd5;
    sif.req_wdata = 8'h3A;
    mid();
    check("pt_ready", sif.req_ready, 1);
    check("pt_en",    sif.bram_en, 1);
    check("pt_we",    sif.bram_we, 1);
    check("pt_addr",  sif.bram_addr, 5);
    check("pt_din",   sif.bram_din, 8'h3A);
    step();

    // Read-only passthrough
    sif.req_we   = 1'b0;
    sif.req_addr = 4'd7;
    mid();
    check("rd_en",   sif.bram_en, 1);
    check("rd_we",   sif.bram_we, 0);
    check("rd_addr", sif.bram_addr, 7);
    step();

    // Start collides with a request; request held through the sweep; second start ignored
    sif.req_we    = 1'b1;
    sif.req_addr  = 4'd2;
    sif.req_wdata = 8'h11;
    start = 1'b1;
    mid();
    check("col_ready", sif.req_ready, 0);
    check("col_en",    sif.bram_en, 0);
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      start = (i == 3);
      mid();
      check("sw2_ready", sif.req_ready, 0);
      check("sw2_addr",  sif.bram_addr, i);
      check("sw2_din",   sif.bram_din, 8'hFF);
      check("sw2_busy",  busy, 1);
      step();
    end
    start = 1'b0;
    mid();
    check("sw2_done",     done, 1);
    check("sw2_acc_rdy",  sif.req_ready, 1);
    check("sw2_acc_en",   sif.bram_en, 1);
    check("sw2_acc_addr", sif.bram_addr, 2);
    check("sw2_acc_din",  sif.bram_din, 8'h11);
    step();
    sif.req_valid = 1'b0;
    mid();
    check("sw2_one_done", done, 0);
    check("sw2_no_busy",  busy, 0);
    check("sw2_idle_en",  sif.bram_en, 0);
    step();

    // Out-of-range request is accepted but dropped
    sif.req_valid = 1'b1;
    sif.req_we    = 1'b1;
    sif.req_addr  = 4'd8;
    sif.req_wdata = 8'h77;
    mid();
    check("oor_ready", sif.req_ready, 1);
    check("oor_en",    sif.bram_en, 0);
    check("oor_we",    sif.bram_we, 0);
    step();
    sif.req_valid = 1'b0;
    step();

    // Reset in the middle of a sweep
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    mid();
    check("mr_pre_addr", sif.bram_addr, 2);
    step();
    rst_n = 1'b0;
    #1;
    check("mr_busy",  busy, 0);
    check("mr_en",    sif.bram_en, 0);
    check("mr_ready", sif.req_ready, 0);
    check("mr_done",  done, 0);
    step();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      if (done) seen_done = 1'b1;
      step();
    end
    check("mr_no_done", seen_done, 0);

    // Fresh sweep after the aborted one restarts from cell 0
    start = 1'b1;
    step();
    start = 1'b0;
    writes = 0;
    bad_addr = 0;
    for (int i = 0; i < 8; i++) begin
      mid();
      if (sif.bram_en && sif.bram_we) writes++;
      if (sif.bram_addr != 4'(i)) bad_addr++;
      step();
    end
    check("rs_writes",   writes, 8);
    check("rs_bad_addr", bad_addr, 0);
    mid();
    check("rs_done", done, 1);
    step();

    // Full-size frame
    start_big = 1'b1;
    step();
    start_big = 1'b0;
    writes = 0;
    bad_addr = 0;
    last_addr = -1;
    seen_done = 1'b0;
    budget = 80000;
    while (budget > 0 && !seen_done) begin
      mid();
      if (done_big) seen_done = 1'b1;
      else if (bif.bram_en && bif.bram_we) begin
        if (int'(bif.bram_addr) != writes) bad_addr++;
        if (bif.bram_din != 8'hFF) bad_addr++;
        last_addr = int'(bif.bram_addr);
        writes++;
      end
      budget--;
      step();
    end
    check("big_done_seen", seen_done, 1);
    check("big_writes",    writes, 76800);
    check("big_last_addr", last_addr, 76799);
    check("big_bad",       bad_addr, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
